led_pattern_seq: RTL
====================

# led_pattern_seq

Downstream consumer of the board's slow-clock divider: takes the divided square wave (about 1 Hz) as a step source and advances a multi-LED display pattern once per rising edge. Four switch-selectable patterns are supported: rotate, bounce, binary count and blink. Runs entirely in the `clk_in` domain and drives the Basys3 LED bank directly.

## Interface
- `WIDTH`, 16, number of LEDs driven; legal range 4..16.
- `clk_in` input 1: board clock (100 MHz); all logic on its rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `step_in` input 1: slow square wave from the divider. It is already registered in `clk_in`, so no synchroniser is needed.
- `mode_in` input 2: pattern select. 00 SHIFT, 01 BOUNCE, 10 COUNT, 11 BLINK.
- `run_in` input 1: 1 = advance on ticks; 0 = freeze the pattern.
- `led_out` output WIDTH: current pattern, registered.
- `wrap_out` output 1: one-cycle pulse when the pattern completes a full period.

## Operation
- Edge detect:
  - `step_q` is a registered copy of `step_in`.
  - `tick = step_in & ~step_q`.
  - `step_q` always tracks `step_in`, regardless of `run_in` or mode.
- Mode tracking: `mode_q` is a registered copy of `mode_in`. A reload occurs when `mode_in != mode_q`.
- Reload values:
  - SHIFT: 0x0001; BOUNCE: 0x0001 with dir=LEFT.
  - COUNT: 0; BLINK: 0.
- Step rules, applied when `tick & run_in` and no reload is pending:
  - SHIFT: rotate left by 1. MSB→bit0 asserts `wrap_out`.
  - BOUNCE: FSM with states LEFT and RIGHT.
    - LEFT shifts left; on reaching bit WIDTH-1, go to RIGHT.
    - RIGHT shifts right; on reaching bit0, go to LEFT and assert `wrap_out`.
    - The lit LED is never blank and never duplicated. Period is 2·(WIDTH-1) ticks.
  - COUNT: increment modulo 2^WIDTH. Overflow (all-ones→0) asserts `wrap_out`.
  - BLINK: toggle all-off/all-ones. The on→off transition asserts `wrap_out`.
- Priority: reset > reload > tick.
  - A tick coinciding with a reload is discarded, with no step and no wrap.
  - A tick while `run_in=0` is discarded. It is not queued.
- Raising `run_in` while `step_in` is already high produces no step. Only a fresh low→high edge does.

## Timing
- Reset values: `led_out`=0x0001, `wrap_out`=0, `mode_q`=00, dir=LEFT, `step_q`=1.
  - Because `step_q` resets to 1, holding `step_in` high through reset release generates no tick.
- Reload takes effect the first cycle after reset if `mode_in≠00`.
- Step latency: `led_out` updates on the first `clk_in` edge at which `step_in` is sampled high after having been sampled low. That is one edge, with no extra pipeline stage.
- Reload latency: `led_out` takes its reload value on the first edge at which the new `mode_in` is sampled.
- `wrap_out` is asserted on the same edge as the wrapping `led_out` update and deasserted on the next edge. Two ticks can never be closer than 2 cycles.
- Reset mid-operation overrides everything on that edge. The FSM and pattern return to reset values with no partial step.
- Bits of `led_out` above WIDTH do not exist. All shifts and rotates are confined to WIDTH bits.

## Structure
- Package `led_seq_pkg`:
  - mode encodings `MODE_SHIFT/BOUNCE/COUNT/BLINK`;
  - BOUNCE direction enum `DIR_LEFT/DIR_RIGHT`;
  - reload constants as functions of WIDTH.
- Sub-module `rise_edge_det`: holds `step_q`, with reset value 1, and outputs `tick`. It is reusable for debounced buttons later.
- Top: mode register, direction FSM, pattern register, wrap register. Target 150–250 lines.

## Test plan
- Reset with `mode_in`=00, `run_in`=1, WIDTH=16; toggle `step_in` 16 times:
  - `led_out` is 0x0002…0x8000, then 0x0001;
  - `wrap_out` is high for exactly one cycle on the 16th step only.
- BOUNCE, WIDTH=16, 30 rising edges:
  - tick 15 gives 0x8000 and tick 16 gives 0x4000;
  - tick 30 gives 0x0001 with a single `wrap_out` pulse.
- COUNT, WIDTH=4, 16 edges: values 1…15, then 0 with `wrap_out`. BLINK, 4 edges: F,0,F,0 with `wrap_out` on edges 2 and 4.
- `run_in`=0 across 5 edges: `led_out` unchanged and no `wrap_out`. Raise `run_in` while `step_in`=1: no step until the next low→high.
- Mode change SHIFT→COUNT on the same edge as a tick, with `led_out`=0x0008: `led_out`=0x0000 next cycle, no increment, no `wrap_out`.
- Hold `step_in`=1 and assert `rst_in` mid-BOUNCE (dir=RIGHT), then release:
  - `led_out`=0x0001, dir=LEFT, no step until `step_in` falls and rises;
  - the first step gives 0x0002.

Source files
------------

// File: rtl/led_pattern_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode and direction
// encodings plus the per-mode reload pattern.
package led_seq_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Reload pattern at full width; callers keep the low WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] reload_value(input mode_e mode);
    logic [MAX_WIDTH-1:0] val;
    case (mode)
      MODE_SHIFT, MODE_BOUNCE: val = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
      default:                 val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control and display signals between a pattern source/consumer and the
// LED sequencer.
interface led_pattern_seq_if #(parameter int WIDTH = 16);
  logic             step_in;
  logic [1:0]       mode_in;
  logic             run_in;
  logic [WIDTH-1:0] led_out;
  logic             wrap_out;

  modport master (output step_in, mode_in, run_in, input  led_out, wrap_out);
  modport slave  (input  step_in, mode_in, run_in, output led_out, wrap_out);
endinterface

// File: rtl/rise_edge_det.sv
// Rising-edge detector for an already-synchronous level; the reset value
// lets a signal held high through reset produce no spurious edge.
module rise_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic tick_out
);

  logic sig_d, sig_q;

  always_comb sig_d = sig_in;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) sig_q <= RESET_VAL;
    else        sig_q <= sig_d;
  end

  assign tick_out = sig_in & ~sig_q;

endmodule

// File: rtl/led_pattern_seq.sv
// Multi-LED pattern sequencer advancing once per rising edge of a slow step
// wave: rotate, bounce, binary count or blink, with a wrap pulse per period.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  led_pattern_seq_if.slave bus
);

  logic             tick;
  logic             reload;
  logic             advance;
  logic [MAX_WIDTH-1:0] reload_full;

  mode_e            mode_d, mode_q;
  dir_e             dir_d,  dir_q;
  logic [WIDTH-1:0] led_d,  led_q;
  logic             wrap_d, wrap_q;

  rise_edge_det #(.RESET_VAL(1'b1)) u_step_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (bus.step_in),
    .tick_out (tick)
  );

  assign reload      = (bus.mode_in != mode_q);
  assign advance     = tick & bus.run_in;
  assign reload_full = reload_value(mode_e'(bus.mode_in));

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mode_d = mode_e'(bus.mode_in);
    dir_d  = dir_q;
    led_d  = led_q;
    wrap_d = 1'b0;

    if (reload) begin
      // A tick landing on a mode change is dropped: no step, no wrap.
      led_d = reload_full[WIDTH-1:0];
      dir_d = DIR_LEFT;
    end else if (advance) begin
      case (mode_q)
        MODE_SHIFT: begin
          led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          wrap_d = led_q[WIDTH-1];
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            led_d = led_q << 1;
            if (led_q[WIDTH-2]) dir_d = DIR_RIGHT;
          end else begin
            led_d = led_q >> 1;
            if (led_q[1]) begin
              dir_d  = DIR_LEFT;
              wrap_d = 1'b1;
            end
          end
        end
        MODE_COUNT: begin
          led_d  = led_q + WIDTH'(1);
          wrap_d = &led_q;
        end
        default: begin
          led_d  = (led_q == '0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          wrap_d = (led_q != '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q <= MODE_SHIFT;
      dir_q  <= DIR_LEFT;
      led_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.wrap_out = wrap_q;

endmodule
